// File: rtl/nios2_system_fb_reader.sv
// nios2_system_fb_reader: framebuffer scan-out reader, s2 word reads -> credit FIFO -> 16-bit pixel stream
module nios2_system_fb_reader #(
    parameter int H_PIXELS   = 320,
    parameter int V_LINES    = 240,
    parameter int BASE_WORD  = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sop,
    output logic        pix_eol,
    output logic        pix_eop,
    output logic        busy
);
    localparam int WORDS = H_PIXELS * V_LINES / 2;
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int XW = H_PIXELS > 1 ? $clog2(H_PIXELS) : 1;
    localparam int YW = V_LINES > 1 ? $clog2(V_LINES) : 1;
    localparam logic [15:0] FIRST = 16'(BASE_WORD);
    localparam logic [15:0] LAST = 16'(BASE_WORD + WORDS - 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state, state_nx;
    logic            inflight;
    logic [AW:0]     count;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [31:0]     head;
    logic            half;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            credit, accept, pop;

    assign credit = ({1'b0, count} + {{(AW + 1){1'b0}}, inflight}) < (AW + 2)'(FIFO_DEPTH);
    assign accept = pix_valid & pix_ready;
    assign pop    = accept & half;
    assign head   = mem[rd_ptr];

    // next state and read strobe; enable only matters in IDLE and at the last-word issue
    always_comb begin
        m_read   = state == FETCH && credit;
        state_nx = state == IDLE  ? (enable ? FETCH : IDLE) :
                   state == FETCH ? ((m_read && m_address == LAST && !enable) ? DRAIN : FETCH) :
                   (!inflight && count == 0) ? IDLE : DRAIN;
    end

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end

    // word address: parked at the frame base while idle, wraps after the last word
    always_ff @(posedge clk) begin
        if (reset || state == IDLE)
            m_address <= FIRST;
        else if (m_read)
            m_address <= m_address == LAST ? FIRST : m_address + 16'd1;
    end

    // read-in-flight flag and FIFO pointers; a read issued during reset is never captured
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= m_read;
            wr_ptr   <= wr_ptr + AW'(inflight);
            rd_ptr   <= rd_ptr + AW'(pop);
            count    <= count + (AW + 1)'(inflight) - (AW + 1)'(pop);
        end
    end

    // FIFO storage, written with the data returned one cycle after each read
    always_ff @(posedge clk) begin
        if (inflight)
            mem[wr_ptr] <= m_readdata;
    end

    // half-word select and raster position, both advanced per accepted pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            half <= 1'b0;
            x    <= '0;
            y    <= '0;
        end else if (accept) begin
            half <= ~half;
            x    <= x == X_LAST ? '0 : x + XW'(1);
            y    <= x == X_LAST ? (y == Y_LAST ? '0 : y + YW'(1)) : y;
        end
    end

    // pixel stream: low half first, markers derived from the raster position
    always_comb begin
        pix_valid = count != 0;
        pix_data  = pix_valid ? (half ? head[31:16] : head[15:0]) : 16'h0;
        pix_sop   = pix_valid && x == '0 && y == '0;
        pix_eol   = pix_valid && x == X_LAST;
        pix_eop   = pix_eol && y == Y_LAST;
        busy      = state != IDLE;
    end
endmodule
